// File: rtl/eth_tx_payload_buffer_if.sv
// Producer/transmitter bundle of the TX payload buffer; slave = buffer, master = environment.
interface eth_tx_payload_buffer_if;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_last;
  logic        wr_ready;
  logic [31:0] data;
  logic [10:0] data_count;
  logic        data_ack;
  logic        busy;
  logic        tx_start;
  logic        frame_ready;
  logic [15:0] payload_sum;
  logic        overflow;

  modport master (
    output wr_valid, wr_data, wr_last, data_ack, busy,
    input  wr_ready, data, data_count, tx_start, frame_ready, payload_sum, overflow
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, data_ack, busy,
    output wr_ready, data, data_count, tx_start, frame_ready, payload_sum, overflow
  );
endinterface

// File: rtl/eth_tx_payload_buffer.sv
// Captures one payload frame, then starts the transmitter and streams it; PAYLOAD_SUM_EN adds a 16-bit one's-complement sum.
// data follows data_ack by one cycle; wr_ready drops from frame completion until the frame has drained.
module eth_tx_payload_buffer #(
  parameter int DEPTH_WORDS = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  eth_tx_payload_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  // DROP swallows the tail of an oversized frame so the producer is never stalled mid-frame.
  typedef enum logic [2:0] {FILL, DROP, ARM, STREAM, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [10:0]    data_count_q, data_count_d;
  logic           wr_ready_q, wr_ready_d;
  logic           tx_start_q, tx_start_d;
  logic           frame_ready_q, frame_ready_d;
  logic           overflow_q, overflow_d;
  logic           accept;
  logic           mem_we;

  logic [31:0]    mem [DEPTH_WORDS];
  logic [31:0]    rd_data_q;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    data_count_d = data_count_q;
    tx_start_d   = 1'b0;
    overflow_d   = overflow_q;
    mem_we       = 1'b0;
    accept       = bus.wr_valid && wr_ready_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (bus.wr_last || (wptr_q == AW'(DEPTH_WORDS - 1))) begin
            data_count_d = 11'(wptr_q) + 11'd1;
            if (bus.wr_last) begin
              state_d = ARM;
            end else begin
              state_d    = DROP;
              overflow_d = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (accept && bus.wr_last) state_d = ARM;
      end
      ARM: begin
        if (!bus.busy) begin
          tx_start_d = 1'b1;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (bus.data_ack) begin
          rptr_d = rptr_q + 1'b1;
          if (11'(rptr_q) == data_count_q - 11'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.busy) begin
          state_d = FILL;
          wptr_d  = '0;
          rptr_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase

    wr_ready_d    = (state_d == FILL) || (state_d == DROP);
    frame_ready_d = (state_d == ARM) || (state_d == STREAM) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      wptr_q        <= '0;
      rptr_q        <= '0;
      data_count_q  <= '0;
      wr_ready_q    <= 1'b1;
      tx_start_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      data_count_q  <= data_count_d;
      wr_ready_q    <= wr_ready_d;
      tx_start_q    <= tx_start_d;
      frame_ready_q <= frame_ready_d;
      overflow_q    <= overflow_d;
    end
  end

  // Read address is the next read pointer, so the RAM output already holds mem[rptr_q].
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q] <= bus.wr_data;
    rd_data_q <= mem[rptr_d];
  end

  assign bus.wr_ready    = wr_ready_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.overflow    = overflow_q;
  assign bus.data_count  = data_count_q;
  assign bus.data        = ((state_q == FILL) || (state_q == DROP)) ? 32'h0 : rd_data_q;

`ifdef PAYLOAD_SUM_EN
  logic [15:0] sum_q, sum_d;
  logic [16:0] add_hi, add_lo;
  logic [15:0] fold_hi;

  always_comb begin
    add_hi  = {1'b0, sum_q} + {1'b0, bus.wr_data[31:16]};
    fold_hi = add_hi[15:0] + {15'd0, add_hi[16]};
    add_lo  = {1'b0, fold_hi} + {1'b0, bus.wr_data[15:0]};
    sum_d   = sum_q;
    if ((state_q == DRAIN) && !bus.busy) begin
      sum_d = '0;
    end else if (mem_we) begin
      sum_d = add_lo[15:0] + {15'd0, add_lo[16]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign bus.payload_sum = sum_q;
`else
  assign bus.payload_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_eth_tx_payload_buffer.sv
// Directed bench for eth_tx_payload_buffer with a 16-word buffer.
module tb_eth_tx_payload_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   pulses;

  eth_tx_payload_buffer_if bus();

  eth_tx_payload_buffer #(.DEPTH_WORDS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef PAYLOAD_SUM_EN
  localparam logic [15:0] SUM_EXP = 16'h0002;
`else
  localparam logic [15:0] SUM_EXP = 16'h0000;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] d, input logic last);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_last  = last;
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic ack_word();
    bus.data_ack = 1'b1;
    tick();
    bus.data_ack = 1'b0;
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = 32'h0;
    bus.wr_last  = 1'b0;
    bus.data_ack = 1'b0;
    bus.busy     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_data", bus.data, 0);
    chk("rst_data_count", bus.data_count, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_frame_ready", bus.frame_ready, 0);
    chk("rst_payload_sum", bus.payload_sum, 0);
    chk("rst_overflow", bus.overflow, 0);
    rst_n = 1'b1;
    tick();

    // 3-word frame, with stray acks in FILL and ARM
    bus.data_ack = 1'b1;
    put(32'h11223344, 1'b0);
    bus.data_ack = 1'b0;
    put(32'h55667788, 1'b0);
    put(32'h99AABBCC, 1'b1);
    chk("t1_data_count", bus.data_count, 3);
    chk("t1_wr_ready_arm", bus.wr_ready, 0);
    chk("t1_frame_ready", bus.frame_ready, 1);
    chk("t1_no_start_yet", bus.tx_start, 0);
    bus.data_ack = 1'b1;
    tick();
    bus.data_ack = 1'b0;
    chk("t1_tx_start", bus.tx_start, 1);
    chk("t1_word0", bus.data, 32'h11223344);
    tick();
    chk("t1_start_one_cycle", bus.tx_start, 0);
    chk("t1_word0_hold", bus.data, 32'h11223344);
    ack_word();
    chk("t1_word1", bus.data, 32'h55667788);
    tick();
    chk("t1_word1_hold", bus.data, 32'h55667788);
    ack_word();
    chk("t1_word2", bus.data, 32'h99AABBCC);
    bus.busy = 1'b1;
    ack_word();
    chk("t1_drain_frame_ready", bus.frame_ready, 1);
    chk("t1_drain_wr_ready", bus.wr_ready, 0);
    tick();
    chk("t1_drain_busy_hold", bus.wr_ready, 0);
    bus.busy = 1'b0;
    tick();
    chk("t1_fill_wr_ready", bus.wr_ready, 1);
    chk("t1_fill_frame_ready", bus.frame_ready, 0);
    chk("t1_fill_data", bus.data, 0);

    // Start held off by busy
    bus.busy = 1'b1;
    put(32'hDEADBEEF, 1'b1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.tx_start) pulses++;
    end
    chk("t2_no_start_while_busy", pulses, 0);
    bus.busy = 1'b0;
    tick();
    chk("t2_tx_start", bus.tx_start, 1);
    chk("t2_word0", bus.data, 32'hDEADBEEF);
    chk("t2_data_count", bus.data_count, 1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.tx_start) pulses++;
    end
    chk("t2_single_pulse", pulses, 0);
    ack_word();
    tick();
    chk("t2_back_to_fill", bus.wr_ready, 1);

    // Payload sum
    put(32'hFFFF0001, 1'b0);
    put(32'h00010000, 1'b1);
    chk("t4_sum_arm", bus.payload_sum, SUM_EXP);
    tick();
    chk("t4_sum_stream", bus.payload_sum, SUM_EXP);
    ack_word();
    ack_word();
    tick();
    chk("t4_fill_wr_ready", bus.wr_ready, 1);
    chk("t4_sum_cleared", bus.payload_sum, 0);

    // Overflow: 21 words into a 16-word buffer, wr_last on the final one
    for (int i = 0; i < 21; i++) begin
      put(32'hC0000000 + 32'(i), (i == 20));
    end
    chk("t3_overflow", bus.overflow, 1);
    chk("t3_data_count", bus.data_count, 16);
    tick();
    chk("t3_tx_start", bus.tx_start, 1);
    chk("t3_mem0_kept", bus.data, 32'hC0000000);
    for (int i = 0; i < 15; i++) ack_word();
    chk("t3_last_held_word", bus.data, 32'hC000000F);
    chk("t3_still_streaming", bus.frame_ready, 1);
    ack_word();
    tick();
    chk("t3_back_to_fill", bus.wr_ready, 1);
    chk("t3_overflow_sticky", bus.overflow, 1);

    // Reset during STREAM
    put(32'hA0A0A0A0, 1'b0);
    put(32'hA1A1A1A1, 1'b0);
    put(32'hA2A2A2A2, 1'b0);
    put(32'hA3A3A3A3, 1'b1);
    tick();
    ack_word();
    ack_word();
    chk("t5_word2", bus.data, 32'hA2A2A2A2);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_wr_ready", bus.wr_ready, 1);
    chk("t5_rst_data", bus.data, 0);
    chk("t5_rst_data_count", bus.data_count, 0);
    chk("t5_rst_frame_ready", bus.frame_ready, 0);
    chk("t5_rst_tx_start", bus.tx_start, 0);
    chk("t5_rst_overflow", bus.overflow, 0);
    chk("t5_rst_payload_sum", bus.payload_sum, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    put(32'hB0B0B0B0, 1'b0);
    put(32'hB1B1B1B1, 1'b1);
    chk("t5_new_count", bus.data_count, 2);
    tick();
    chk("t5_new_start", bus.tx_start, 1);
    chk("t5_new_word0", bus.data, 32'hB0B0B0B0);
    ack_word();
    chk("t5_new_word1", bus.data, 32'hB1B1B1B1);
    ack_word();
    tick();
    chk("t5_back_to_fill", bus.wr_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_tx_payload_buffer.md
Name: eth_tx_payload_buffer

Overview:
- Upstream feeder for the TCP/IP frame transmitter: captures one frame's payload as 32-bit words from a producer, then starts the transmitter and streams words to it.
- Presents the current payload word and the payload word count, and pulses the transmitter start once the frame is complete and the transmitter is idle.
- Computes the 16-bit one's-complement sum of the payload, so firmware can complete the TCP checksum before start.

Parameters:
- DEPTH_WORDS, 512, payload storage depth in 32-bit words (power of 2, max 1024).
- AW, $clog2(DEPTH_WORDS), address width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  producer word valid
- wr_data  in  32  payload word; byte [31:24] goes on the wire first
- wr_last  in  1  marks the final word of the frame, qualified by wr_valid
- wr_ready  out  1  buffer accepts a word this cycle
- data  out  32  word currently offered to the transmitter
- data_count  out  11  payload length in words of the held frame
- data_ack  in  1  one-cycle pulse from the transmitter: current word consumed
- busy  in  1  transmitter busy
- tx_start  out  1  one-cycle start pulse, drives transmitter en_i
- frame_ready  out  1  complete frame held, not yet fully streamed
- payload_sum  out  16  one's-complement sum of payload half-words
- overflow  out  1  sticky: frame exceeded DEPTH_WORDS

Behaviour:
- Clock and reset: one clock clk; asynchronous active-low reset rst_n.
- Reset values: wr_ready=1, data=0, data_count=0, tx_start=0, frame_ready=0, payload_sum=0, overflow=0; state=FILL; all pointers 0.
- Reset mid-operation discards the frame at once.
- FILL:
  - wr_ready=1.
  - Each wr_valid cycle writes mem[wptr] and increments wptr.
  - With wr_last, or when a word is written at wptr==DEPTH_WORDS-1: latch data_count=wptr+1 and go to ARM.
  - In the DEPTH_WORDS-1 case without wr_last, also set overflow=1 and ignore the remaining words until wr_last.
- ARM:
  - wr_ready=0, frame_ready=1.
  - Wait until busy==0 for one full cycle, then pulse tx_start for exactly one cycle and go to STREAM.
  - data=mem[0] is valid no later than the tx_start cycle.
- STREAM:
  - On each data_ack: rptr+1, and data shows mem[rptr+1] on the next cycle, so the transmitter has 1-cycle latency.
  - On the data_ack when rptr==data_count-1: go to DRAIN.
  - data_ack when not in STREAM is ignored.
- DRAIN: wait for busy==0, then clear frame_ready, reset wptr and rptr to 0, and go to FILL.
- Zero-length frame (wr_last on an empty buffer is impossible, since wr_last carries a word): minimum data_count is 1.
- Simultaneous wr_valid and data_ack: wr_valid is blocked (wr_ready=0) outside FILL, so no conflict.
- overflow clears only on reset.
- Memory: inferred simple dual-port RAM with synchronous read.
- The read address is pre-fetched one word ahead so data updates the cycle after data_ack.

Optional Feature:
- Macro: PAYLOAD_SUM_EN.
- Defined:
  - On each accepted word, sum = sum + wr_data[31:16] + wr_data[15:0] with end-around carry, using a 17-bit intermediate, folded twice.
  - payload_sum holds the uncomplemented sum of the held frame from ARM onward.
  - Cleared on entry to FILL.
- Undefined: payload_sum is tied to 16'h0000 and no adder logic is present.

Test Plan:
- 3-word frame 0x11223344, 0x55667788, 0x99AABBCC (last on word 3) with busy=0 -> data_count=3, tx_start pulses once, and data sequence 0x11223344→0x55667788→0x99AABBCC on successive data_ack; after busy falls, state returns to FILL with wr_ready=1.
- Frame complete while busy=1 for 20 cycles -> no tx_start until 1 cycle after busy falls; exactly one pulse.
- DEPTH_WORDS+5 words without wr_last until the end -> overflow=1, data_count=DEPTH_WORDS, extra words dropped, mem[0] unchanged.
- PAYLOAD_SUM_EN, words 0xFFFF0001 and 0x00010000 -> payload_sum=0x0002; macro off -> payload_sum=0x0000.
- rst_n low during STREAM after 2 acks -> all outputs return to reset values asynchronously; the next frame streams from word 0.
- data_ack pulses in FILL and ARM -> ignored, rptr stays 0, first streamed word is mem[0].
